// File: rtl/hdmi_timing.sv
// -----------------------------------------------------------------------------
// hdmi_timing
//
// Raster timing generator for the 640x480@60 display path. The system clock
// is divided down to the pixel rate, and horizontal and vertical counters
// sweep the full raster, blanking included.
//
// All outputs are registers. On every clk edge they are loaded from the
// counters' *next* values. As a result x, y, hsync, vsync and video_on always
// describe the same pixel, with no extra pipeline latency.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   x          out  current horizontal position, 0..H_TOTAL-1
//   y          out  current vertical position, 0..V_TOTAL-1
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high inside the visible area
//   p_clock    out  50%-duty pixel clock, period CLK_DIV clks
//   frame_tick out  one-clk pulse when position (0,0) is entered
//
// Both totals must fit in 10 bits. CLK_DIV must be even and >= 2.
// -----------------------------------------------------------------------------
module hdmi_timing #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_clock,
   output logic       frame_tick
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic             p_tick;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic [9:0]       h_nxt;
   logic [9:0]       v_nxt;
   logic             h_wrap;
   logic             v_wrap;

   // Next-state values. Every registered output is derived from these, so the
   // outputs change on the same edge as the counters.
   always_comb begin
      p_tick  = (div_cnt == DIV_LAST);
      h_wrap  = (h_cnt == H_LAST);
      v_wrap  = (v_cnt == V_LAST);
      div_nxt = p_tick ? '0 : div_cnt + 1'b1;
      h_nxt   = h_cnt;
      v_nxt   = v_cnt;
      if (p_tick) begin
         if (h_wrap) begin
            h_nxt = '0;
            v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
         end else begin
            h_nxt = h_cnt + 10'd1;
         end
      end
   end

   // Reset parks the counters on the last pixel of the frame. The first
   // p_tick after release therefore wraps them to (0,0) and fires frame_tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         h_cnt      <= H_LAST;
         v_cnt      <= V_LAST;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         video_on   <= 1'b0;
         p_clock    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         div_cnt    <= div_nxt;
         h_cnt      <= h_nxt;
         v_cnt      <= v_nxt;
         hsync      <= !((h_nxt >= HS_START) && (h_nxt <= HS_END));
         vsync      <= !((v_nxt >= VS_START) && (v_nxt <= VS_END));
         video_on   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         // The pixel clock falls on the counter-update edge and rises half a
         // pixel later. Downstream posedge capture then sees settled outputs.
         p_clock    <= (div_nxt >= DIV_HALF);
         frame_tick <= p_tick && h_wrap && v_wrap;
      end
   end

   assign x = h_cnt;
   assign y = v_cnt;

endmodule

// File: tb/tb_hdmi_timing.sv
module tb_hdmi_timing;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic [9:0] x, y;
  logic hsync, vsync, video_on, p_clock, frame_tick;

  // reduced-raster instance: 14 x 7 pixels, CLK_DIV=2
  logic [9:0] sx, sy;
  logic s_hsync, s_vsync, s_video_on, s_p_clock, s_frame_tick;

  hdmi_timing dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_clock(p_clock), .frame_tick(frame_tick)
  );

  hdmi_timing #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset(reset), .x(sx), .y(sy), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .p_clock(s_p_clock), .frame_tick(s_frame_tick)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Sample 1 ns after each active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start-up vectors for the default instance: input = edges since release.
  typedef struct {
    int         edge_n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pc;
    logic       ft;
  } vec_t;

  vec_t tbl[9];

  task automatic check_default_vec(input int i);
    check($sformatf("start%0d.x", i),        x,          tbl[i].x);
    check($sformatf("start%0d.y", i),        y,          tbl[i].y);
    check($sformatf("start%0d.hsync", i),    hsync,      tbl[i].hs);
    check($sformatf("start%0d.vsync", i),    vsync,      tbl[i].vs);
    check($sformatf("start%0d.video_on", i), video_on,   tbl[i].von);
    check($sformatf("start%0d.p_clock", i),  p_clock,    tbl[i].pc);
    check($sformatf("start%0d.frame_tick", i), frame_tick, tbl[i].ft);
  endtask

  // Closed-form model of the reduced instance at edge k after reset release.
  task automatic small_check(input int k);
    int n, idx, ex, ey;
    logic epc, eft;
    n = k / 2;
    if (n == 0) begin
      ex = 13; ey = 6;
    end else begin
      idx = (n - 1) % 98;
      ex  = idx % 14;
      ey  = idx / 14;
    end
    epc = (k % 2) == 1;
    eft = ((k % 2) == 0) && (n >= 1) && (((n - 1) % 98) == 0);
    check($sformatf("s.x@%0d", k),        sx,           ex);
    check($sformatf("s.y@%0d", k),        sy,           ey);
    check($sformatf("s.hsync@%0d", k),    s_hsync,      !(ex >= 10 && ex <= 11));
    check($sformatf("s.vsync@%0d", k),    s_vsync,      !(ey == 5));
    check($sformatf("s.video_on@%0d", k), s_video_on,   (ex < 8) && (ey < 4));
    check($sformatf("s.p_clock@%0d", k),  s_p_clock,    epc);
    check($sformatf("s.frame_tick@%0d", k), s_frame_tick, eft);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".x"},          x,          799);
    check({tag, ".y"},          y,          524);
    check({tag, ".hsync"},      hsync,      1);
    check({tag, ".vsync"},      vsync,      1);
    check({tag, ".video_on"},   video_on,   0);
    check({tag, ".p_clock"},    p_clock,    0);
    check({tag, ".frame_tick"}, frame_tick, 0);
    check({tag, ".s_x"},        sx,         13);
    check({tag, ".s_y"},        sy,         6);
    check({tag, ".s_video_on"}, s_video_on, 0);
    check({tag, ".s_p_clock"},  s_p_clock,  0);
  endtask

  // Runs edges 0..8 after release, checking both instances.
  task automatic run_startup_table();
    int edge_cnt;
    edge_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      while (edge_cnt < tbl[i].edge_n) begin
        tick();
        edge_cnt++;
        small_check(edge_cnt);
      end
      check_default_vec(i);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int last_rise, last_fall, rises, x_changes;
    logic [9:0] prev_x;
    logic prev_p, prev_von;
    int hs_low_clks, von_falls, wraps;
    logic [9:0] e;
    int ft_last, ft_count, vs_low_clks;
    bit found;

    tbl[0] = '{0, 799, 524, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 799, 524, 1, 1, 0, 0, 0};
    tbl[2] = '{2, 799, 524, 1, 1, 0, 1, 0};
    tbl[3] = '{3, 799, 524, 1, 1, 0, 1, 0};
    tbl[4] = '{4,   0,   0, 1, 1, 1, 0, 1};
    tbl[5] = '{5,   0,   0, 1, 1, 1, 0, 0};
    tbl[6] = '{6,   0,   0, 1, 1, 1, 1, 0};
    tbl[7] = '{7,   0,   0, 1, 1, 1, 1, 0};
    tbl[8] = '{8,   1,   0, 1, 1, 1, 0, 0};

    // ---- reset / start-up ----
    reset = 1'b0;
    repeat (3) tick();
    check_reset_state("rst");
    reset = 1'b1;
    run_startup_table();

    // ---- pixel clock: 40 clks from edge 8 ----
    prev_x = x; prev_p = p_clock;
    last_rise = -1; last_fall = -1; rises = 0; x_changes = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (p_clock && !prev_p) begin
        if (last_rise >= 0) check("pclk_period", c - last_rise, 4);
        if (last_fall >= 0) check("pclk_low", c - last_fall, 2);
        check("x_stable_at_rise", x, prev_x);
        last_rise = c;
        rises++;
      end
      if (!p_clock && prev_p) begin
        if (last_rise >= 0) check("pclk_high", c - last_rise, 2);
        last_fall = c;
      end
      if (x != prev_x) begin
        check("x_change_on_fall", {prev_p, p_clock}, 2'b10);
        x_changes++;
      end
      prev_x = x; prev_p = p_clock;
    end
    check("pclk_rises", rises, 10);
    check("x_changes", x_changes, 10);
    check("x_after_pclk", x, 11);

    // ---- horizontal line: x 12..799 then wrap to 0 ----
    for (int i = 12; i < 800; i++) exp_q.push_back(10'(i));
    exp_q.push_back(10'd0);
    prev_x = x; prev_von = video_on;
    hs_low_clks = 0; von_falls = 0; wraps = 0;
    for (int c = 0; c < 3300 && exp_q.size() != 0; c++) begin
      tick();
      if (!hsync) hs_low_clks++;
      if (prev_von && !video_on) begin
        check("von_fall_x", x, 640);
        check("von_fall_prev_x", prev_x, 639);
        von_falls++;
      end
      if (x != prev_x) begin
        e = exp_q.pop_front();
        check("x_seq", x, e);
        check("line_video_on", video_on, x < 640);
        check("line_hsync", hsync, !(x >= 656 && x <= 751));
        if (x == 0) begin
          check("y_inc_on_wrap", y, 1);
          wraps++;
        end
      end
      prev_x = x; prev_von = video_on;
    end
    check("line_done", exp_q.size(), 0);
    check("hsync_low_clks", hs_low_clks, 384);
    check("von_falls", von_falls, 1);
    check("line_wraps", wraps, 1);

    // ---- reduced raster: two full frames plus margin ----
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    ft_last = -1; ft_count = 0; vs_low_clks = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      small_check(k);
      if (!s_vsync) vs_low_clks++;
      if (s_frame_tick) begin
        if (ft_last >= 0) check("s.ft_spacing", k - ft_last, 196);
        ft_last = k;
        ft_count++;
      end
    end
    check("s.ft_count", ft_count, 3);
    check("s.vsync_low_clks", vs_low_clks, 56);

    // ---- mid-frame reset at (3,2) on the reduced raster ----
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (sx == 3 && sy == 2) found = 1'b1;
    end
    check("s.reach_3_2", found, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (3) tick();
    reset = 1'b1;
    run_startup_table();
    for (int k = 9; k <= 30; k++) begin
      tick();
      small_check(k);
    end

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
